uart_tx_scheduler: RTL

//  Shares the single UART transmitter among NB_REQ requesters, each offering one NB_WORD-bit word.

---
 rtl/uart_tx_scheduler_pkg.sv | 19 +
 rtl/uart_tx_scheduler_rr_arbiter.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler: FSM encodings, header tag and sizing helpers.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] HDR_TAG     = 4'hA;
  localparam int         NB_BYTE_DEF = 8;

  // A one-requester build still needs a 1-bit index/pointer.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module uart_tx_scheduler_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NB_REQ = 2,
  parameter int IDXW   = idx_width(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req,
  input  logic [IDXW-1:0]   ptr,
  input  logic              enable,
  output logic [NB_REQ-1:0] grant,
  output logic [IDXW-1:0]   idx
);

  logic [2*NB_REQ-1:0] dbl;
  logic [NB_REQ-1:0]   rot;
  logic                found;

  // Doubling the vector turns the rotate into a plain right shift by ptr.
  always_comb begin
    int sum;
    dbl   = {req, req} >> ptr;
    rot   = dbl[NB_REQ-1:0];
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (enable && !found && rot[i]) begin
        found = 1'b1;
        sum   = int'(ptr) + i;
        if (sum >= NB_REQ) sum = sum - NB_REQ;
        idx   = IDXW'(sum);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_grant
      assign grant[gi] = found && (idx == IDXW'(gi));
    end
  endgenerate

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin word scheduler feeding a byte-wide UART TX through a start/done handshake.
// Optional per-word header byte when UART_TX_SCHED_HEADER_EN is defined.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NB_REQ  = 2,
  parameter int NB_WORD = 32,
  parameter int NB_BYTE = NB_BYTE_DEF
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic [NB_REQ-1:0]         i_req,
  input  logic [NB_REQ*NB_WORD-1:0] i_word,
  input  logic                      i_tx_done,
  output logic [NB_REQ-1:0]         o_grant,
  output logic                      o_busy,
  output logic                      o_tx_start,
  output logic [NB_BYTE-1:0]        o_tx_data
);

  localparam int IDXW    = idx_width(NB_REQ);
  localparam int NB_DATA = NB_WORD / NB_BYTE;
`ifdef UART_TX_SCHED_HEADER_EN
  localparam int NB_HDR  = 1;
`else
  localparam int NB_HDR  = 0;
`endif
  localparam int NB_TOTAL = NB_DATA + NB_HDR;
  localparam int CNTW     = $clog2(NB_TOTAL + 1);

  state_t              state_reg, state_next;
  logic [NB_WORD-1:0]  shreg_reg, shreg_next;
  logic [CNTW-1:0]     cnt_reg, cnt_next;
  logic [IDXW-1:0]     ptr_reg, ptr_next;
  logic [IDXW-1:0]     gidx_reg, gidx_next;
  logic                hdr_phase_reg, hdr_phase_next;

  logic [NB_REQ-1:0]   arb_grant;
  logic [IDXW-1:0]     arb_idx;
  logic                arb_en;
  logic                last_byte;
  logic [NB_WORD-1:0]  sel_word;
  logic [NB_WORD-1:0]  word_arr [NB_REQ];
  logic [2:0]          hdr_idx;
  logic [NB_BYTE-1:0]  hdr_byte;

  generate
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_word
      assign word_arr[gi] = i_word[gi*NB_WORD +: NB_WORD];
    end
  endgenerate

  // Arbitration only happens in IDLE, so requests are ignored while busy.
  assign arb_en = (state_reg == ST_IDLE) && !i_reset;

  uart_tx_scheduler_rr_arbiter #(
    .NB_REQ (NB_REQ),
    .IDXW   (IDXW)
  ) u_arb (
    .req    (i_req),
    .ptr    (ptr_reg),
    .enable (arb_en),
    .grant  (arb_grant),
    .idx    (arb_idx)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (arb_grant[i]) sel_word = sel_word | word_arr[i];
    end
  end

  assign last_byte = (cnt_reg == CNTW'(NB_TOTAL - 1));
  assign hdr_idx   = 3'(gidx_reg);
  assign hdr_byte  = NB_BYTE'({HDR_TAG, 1'b0, hdr_idx});

  always_comb begin
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    cnt_next       = cnt_reg;
    ptr_next       = ptr_reg;
    gidx_next      = gidx_reg;
    hdr_phase_next = hdr_phase_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|arb_grant) begin
          shreg_next = sel_word;
          gidx_next  = arb_idx;
          cnt_next   = '0;
`ifdef UART_TX_SCHED_HEADER_EN
          hdr_phase_next = 1'b1;
          state_next     = ST_HDR;
`else
          state_next     = ST_SEND;
`endif
        end
      end
      ST_HDR, ST_SEND: state_next = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          hdr_phase_next = 1'b0;
          if (last_byte) begin
            cnt_next   = '0;
            state_next = ST_IDLE;
            if (gidx_reg == IDXW'(NB_REQ - 1)) ptr_next = '0;
            else                               ptr_next = gidx_reg + 1'b1;
          end else begin
            // The header byte is not part of the shift register.
            if (!hdr_phase_reg) shreg_next = shreg_reg >> NB_BYTE;
            cnt_next   = cnt_reg + 1'b1;
            state_next = ST_SEND;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_reg     <= ST_IDLE;
      shreg_reg     <= '0;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
      gidx_reg      <= '0;
      hdr_phase_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      cnt_reg       <= cnt_next;
      ptr_reg       <= ptr_next;
      gidx_reg      <= gidx_next;
      hdr_phase_reg <= hdr_phase_next;
    end
  end

  assign o_grant    = arb_grant;
  assign o_busy     = (state_reg != ST_IDLE);
  assign o_tx_start = (state_reg == ST_SEND) || (state_reg == ST_HDR);

  always_comb begin
    o_tx_data = '0;
    if (state_reg != ST_IDLE) o_tx_data = hdr_phase_reg ? hdr_byte : shreg_reg[NB_BYTE-1:0];
  end

endmodule
